// File: rtl/reload_counter_arbiter.sv
// Round-robin arbiter that time-shares one self-reloading counter among NUM_REQ
// requesters, handing it over at the counter's wrap with no idle cycle.
module reload_counter_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [NUM_REQ*CNT_W-1:0] val_i,
  input  logic [CNT_W-1:0]         count_i,
  output logic                     load_o,
  output logic [CNT_W-1:0]         load_val_o,
  output logic [NUM_REQ-1:0]       gnt_o,
  output logic [NUM_REQ-1:0]       done_o,
  output logic                     busy_o
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_PRE = {{(CNT_W-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;

  state_t             state_q;
  logic [PTR_W-1:0]   ptr_q;
  logic [PTR_W-1:0]   owner_q;
  logic [CNT_W-1:0]   val_q;

  logic [PTR_W-1:0]   next_ptr;
  logic [PTR_W-1:0]   arb_start;
  logic               win_found;
  logic [PTR_W-1:0]   win_idx;
  logic [CNT_W-1:0]   win_val;
  logic [CNT_W-1:0]   win_clamped;
  logic [NUM_REQ-1:0] win_onehot;

  // In RUN the owner+1 slot has top priority; from IDLE the stored pointer does.
  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    int best_rank;
    int rank;
    next_ptr  = (int'(owner_q) == NUM_REQ - 1) ? '0 : owner_q + 1'b1;
    arb_start = (state_q == RUN) ? next_ptr : ptr_q;
    win_found = 1'b0;
    win_idx   = '0;
    win_val   = '0;
    best_rank = NUM_REQ;
    rank      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rank = (i >= int'(arb_start)) ? i - int'(arb_start)
                                    : i + NUM_REQ - int'(arb_start);
      if (req_i[i] && rank < best_rank) begin
        best_rank = rank;
        win_found = 1'b1;
        win_idx   = PTR_W'(i);
        win_val   = val_i[i*CNT_W +: CNT_W];
      end
    end
    // A reload of all-ones would skip the pre-arm count, so it becomes a 2-cycle window.
    win_clamped = (win_val == CNT_MAX) ? CNT_PRE : win_val;
    win_onehot  = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      val_q   <= '0;
      load_o  <= 1'b0;
      gnt_o   <= '0;
      done_o  <= '0;
      busy_o  <= 1'b0;
    end else begin
      done_o <= '0;
      case (state_q)
        IDLE: begin
          if (win_found) begin
            gnt_o   <= win_onehot;
            owner_q <= win_idx;
            val_q   <= win_clamped;
            load_o  <= 1'b1;
            busy_o  <= 1'b1;
            state_q <= ARM;
          end
        end
        ARM: begin
          // The counter takes val_q on this wrap, starting the owner's window.
          if (count_i == CNT_MAX) state_q <= RUN;
        end
        RUN: begin
          if (count_i == CNT_PRE) begin
            done_o <= gnt_o;
            ptr_q  <= next_ptr;
            if (win_found) begin
              gnt_o   <= win_onehot;
              owner_q <= win_idx;
              val_q   <= win_clamped;
            end else begin
              gnt_o   <= '0;
              load_o  <= 1'b0;
              busy_o  <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign load_val_o = val_q;

endmodule

// File: doc/reload_counter_arbiter.md
# reload_counter_arbiter

Round-robin arbiter that time-shares one self-reloading counter among `NUM_REQ` requesters. Each requester asks for a window starting at its own reload value. The block drives the counter's `load_i`/`load_val_i`, watches `count_o`, and hands the counter from owner to owner on wrap boundaries with no idle cycle between them. It sits between the requester blocks and the counter instance.

## Interface
- `NUM_REQ`, default 4: number of requesters (2..8).
- `CNT_W`, default 4: counter width; fixed at 4 for this design.
- `clk`  in  1  system clock; all state on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_i`  in  NUM_REQ  level request per requester.
- `val_i`  in  NUM_REQ*CNT_W  reload values; requester k uses `val_i[4k+3:4k]`.
- `count_i`  in  CNT_W  counter's `count_o`.
- `load_o`  out  1  to counter `load_i`.
- `load_val_o`  out  CNT_W  to counter `load_val_i`.
- `gnt_o`  out  NUM_REQ  one-hot current or armed owner; zero when idle.
- `done_o`  out  NUM_REQ  one-cycle pulse marking the last cycle of the owner's window.
- `busy_o`  out  1  high whenever `gnt_o` is non-zero.

## Operation
- Counter model:
  - Counts up every cycle.
  - From 4'hF it goes to `load_val_i` if `load_i`=1, else to 0.
- Reset values: state IDLE, all outputs 0, RR pointer 0.
  - Requester 0 has highest priority after reset.
- States: IDLE, ARM, RUN.
- IDLE:
  - `load_o`=0; the counter free-runs and wraps to 0.
  - Any `req_i` bit set: pick the winner round-robin starting at the pointer.
  - Latch the winner's value into `val_q`, set `gnt_o`, go to ARM.
- ARM:
  - `load_o`=1, `load_val_o`=`val_q`.
  - On `count_i`==4'hF, go to RUN. The counter loads `val_q` at that edge.
- RUN:
  - `load_o`=1, `load_val_o`=`val_q`.
  - Window is `val_q`..4'hF, i.e. 16-`val_q` cycles.
  - When `count_i`==4'hE (pre-arm point), at that edge:
    - Register `done_o[owner]`=1 for the next cycle.
    - Advance the RR pointer to owner+1.
    - Arbitrate over current `req_i`, including the owner, with owner+1 highest priority.
  - Winner exists: update `gnt_o` and `val_q`, keep `load_o`=1, stay in RUN. The F cycle then shows the new value on `load_val_o`, and the counter goes F → new value directly.
  - No winner: `load_o`=0, `gnt_o`=0, go to IDLE. The counter wraps F → 0.
- Clamp: a latched value of 4'hF is stored as 4'hE, so every window has at least 2 cycles and always passes 4'hE.
- Requests:
  - `req_i` is sampled only at arbitration points.
  - Dropping `req_i` mid-window does not shorten the window.
  - A held `req_i` is re-granted in RR order.
  - Each grant covers exactly one window.
- `val_i` is sampled only at grant; later changes are ignored.
- Reset asserted in any state clears everything immediately, asynchronously.
  - The counter is not reset by this block.
  - After reset release, arbitration restarts from IDLE.

## Timing
- Grant latency from IDLE: `gnt_o` high one cycle after `req_i` is seen.
- Counter load occurs at the first 4'hF after the grant; worst case 16 cycles.
- Handoff in RUN has zero bubble:
  - `done_o[old]` and `gnt_o[new]` both change at the edge after `count_i`==E.
  - `done_o` coincides with `count_i`==F.
  - The next cycle `count_i` equals the new value.
- `done_o` is exactly one cycle wide per window; at most one bit is set at a time.
- `busy_o` = |`gnt_o`, registered.
- All outputs are registered; no combinational path from `req_i` or `count_i` to any output.

## Test plan
- Reset, then `req_i`=0001, val0=7 (bench instantiates the counter model):
  - `gnt_o`=0001 and `load_o`=1, `load_val_o`=7 after one cycle.
  - After the next F, `count_i` runs 7..F.
  - `done_o`=0001 on the F cycle.
  - Then `load_o`=0, `gnt_o`=0 and `count_i` wraps to 0.
- `req_i`=1111 held for one window each, vals 3,5,9,C:
  - Grant order 0,1,2,3.
  - `count_i` goes F→5, F→9, F→C with no 0 in between.
  - Window lengths 13, 11, 7, 4.
- `req0` and `req2` held continuously, vals 8 and A: grants alternate 0,2,0,2; each `done_o` pulse lands on a count F.
- val1=F, `req_i`=0010: `load_val_o`=E; window is E,F (2 cycles); `done_o[1]` on F.
- `req_i[0]` dropped at `count_i`=9 of a window starting at 4: window still ends at F with `done_o[0]`.
- `reset` pulsed low while in RUN:
  - `gnt_o`, `load_o`, `done_o`, `busy_o` go to 0 immediately.
  - After release with `req_i`=0110, first grant is requester 1.
